// File: rtl/dlx_dbg_pkg.sv
// Shared definitions for the pipeline debug/read-out logic: dump FSM states,
// the halt trap encoding and the address tag used for the checksum beat.
package dlx_dbg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    READ,
    CAPT,
    HOLD,
    DONE
  } dump_state_t;

  localparam logic [31:0] TRAP_HALT     = 32'h4400_0300;
  localparam logic [31:0] CHECKSUM_ADDR = 32'hFFFF_FFFF;

endpackage

// File: rtl/dump_word_assembler.sv
// Byte-lane assembler: DMEM read data arrives one cycle after each strobe and
// is placed big-endian (lane 0 = MSB byte) into the output word.
module dump_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        rd,
  input  logic [1:0]  k,
  input  logic [0:7]  rdata,
  output logic [0:31] word
);

  logic       pend_reg;
  logic [1:0] pend_k_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_reg   <= 1'b0;
      pend_k_reg <= 2'd0;
      word       <= '0;
    end else begin
      pend_reg   <= rd;
      pend_k_reg <= k;
      if (clear)
        word <= '0;
      else if (pend_reg)
        word[{pend_k_reg, 3'b000} +: 8] <= rdata;
    end
  end

endmodule

// File: rtl/dmem_dump_unit.sv
// End-of-program DMEM read-out engine: halts the core on the trap word, drains,
// then streams big-endian words on valid/ready. Optional trailing XOR beat
// is enabled with DMEM_DUMP_CHECKSUM_EN.
module dmem_dump_unit
  import dlx_dbg_pkg::*;
#(
  parameter logic [31:0] TRAP_WORD    = TRAP_HALT,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter logic [31:0] DUMP_BASE    = 32'd0,
  parameter int unsigned DUMP_WORDS   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [0:31] instr_in,
  output logic        halt,
  output logic        dmem_rd,
  output logic [0:31] dmem_addr,
  input  logic [0:7]  dmem_rdata,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [0:31] dump_word,
  output logic [0:31] dump_addr,
  output logic        dump_last,
  output logic        done
);

  localparam logic [7:0]  DRAIN_INIT = 8'(DRAIN_CYCLES);
  localparam logic [15:0] LAST_IDX   = 16'(DUMP_WORDS - 1);

  dump_state_t state_reg, state_next;
  logic [7:0]  drain_cnt_reg;
  logic [15:0] word_idx_reg;
  logic [1:0]  k_reg;
  logic [31:0] addr_reg;
  logic        last_reg;
  logic [31:0] word_base;
  logic [0:31] asm_word;
  logic        data_last;
  logic        sum_next;

  assign word_base = DUMP_BASE + {14'd0, word_idx_reg, 2'b00};

  dump_word_assembler u_asm (
    .clock (clock),
    .reset (reset),
    .clear (state_reg == IDLE),
    .rd    (dmem_rd),
    .k     (k_reg),
    .rdata (dmem_rdata),
    .word  (asm_word)
  );

`ifdef DMEM_DUMP_CHECKSUM_EN
  logic [0:31] xor_reg;
  logic        sum_beat_reg;

  // The XOR beat reuses HOLD; sum_beat_reg switches the word mux to the XOR.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      xor_reg      <= '0;
      sum_beat_reg <= 1'b0;
    end else if (state_reg == IDLE) begin
      xor_reg      <= '0;
      sum_beat_reg <= 1'b0;
    end else if (state_reg == HOLD && dump_ready && !sum_beat_reg) begin
      xor_reg <= xor_reg ^ asm_word;
      if (sum_next)
        sum_beat_reg <= 1'b1;
    end
  end

  assign dump_word = sum_beat_reg ? xor_reg : asm_word;
  assign data_last = 1'b0;
  assign sum_next  = (word_idx_reg == LAST_IDX) && !sum_beat_reg;
`else
  assign dump_word = asm_word;
  assign data_last = (word_idx_reg == LAST_IDX);
  assign sum_next  = 1'b0;
`endif

  assign dump_addr = addr_reg;
  assign dump_last = last_reg;

  always_comb begin
    state_next = state_reg;
    halt       = (state_reg != IDLE);
    dmem_rd    = 1'b0;
    dmem_addr  = '0;
    dump_valid = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE:  if (instr_in == TRAP_WORD) state_next = DRAIN;
      DRAIN: if (drain_cnt_reg == 8'd0) state_next = READ;
      READ: begin
        dmem_rd   = 1'b1;
        dmem_addr = word_base + {30'd0, k_reg};
        if (k_reg == 2'd3) state_next = CAPT;
      end
      CAPT:  state_next = HOLD;
      HOLD: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (last_reg)      state_next = DONE;
          else if (!sum_next) state_next = READ;
        end
      end
      DONE:    done = 1'b1;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      drain_cnt_reg <= 8'd0;
      word_idx_reg  <= 16'd0;
      k_reg         <= 2'd0;
      addr_reg      <= 32'd0;
      last_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          word_idx_reg <= 16'd0;
          k_reg        <= 2'd0;
          if (instr_in == TRAP_WORD) drain_cnt_reg <= DRAIN_INIT;
        end
        DRAIN: if (drain_cnt_reg != 8'd0) drain_cnt_reg <= drain_cnt_reg - 8'd1;
        READ:  k_reg <= k_reg + 2'd1;
        CAPT: begin
          addr_reg <= word_base;
          last_reg <= data_last;
        end
        HOLD: begin
          if (dump_ready && !last_reg) begin
            if (sum_next) begin
              addr_reg <= CHECKSUM_ADDR;
              last_reg <= 1'b1;
            end else begin
              word_idx_reg <= word_idx_reg + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_dump_unit.sv
// Scoreboard bench for dmem_dump_unit: a default instance and a small
// single-word instance, both reading a shared byte-array DMEM model.
module tb_dmem_dump_unit;
  import dlx_dbg_pkg::*;

`ifdef DMEM_DUMP_CHECKSUM_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    logic        last;
  } beat_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [31:0] instr_in, dmem_addr, dump_word, dump_addr;
  logic        halt, dmem_rd, dump_valid, dump_ready, dump_last, done;
  logic [7:0]  dmem_rdata;

  logic [31:0] s_instr, s_dmem_addr, s_dump_word, s_dump_addr;
  logic        s_halt, s_dmem_rd, s_dump_valid, s_dump_ready, s_dump_last, s_done;
  logic [7:0]  s_dmem_rdata;

  logic [7:0] mem [0:511];
  beat_t exp_q[$];
  beat_t exp_s_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  dmem_dump_unit u_dut (
    .clock(clock), .reset(reset), .instr_in(instr_in), .halt(halt),
    .dmem_rd(dmem_rd), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_word(dump_word),
    .dump_addr(dump_addr), .dump_last(dump_last), .done(done)
  );

  dmem_dump_unit #(
    .DRAIN_CYCLES(0), .DUMP_BASE(32'h100), .DUMP_WORDS(1)
  ) u_small (
    .clock(clock), .reset(reset), .instr_in(s_instr), .halt(s_halt),
    .dmem_rd(s_dmem_rd), .dmem_addr(s_dmem_addr), .dmem_rdata(s_dmem_rdata),
    .dump_valid(s_dump_valid), .dump_ready(s_dump_ready), .dump_word(s_dump_word),
    .dump_addr(s_dump_addr), .dump_last(s_dump_last), .done(s_done)
  );

  // Registered DMEM read port: data one cycle after the address.
  always @(posedge clock) begin
    dmem_rdata   <= mem[dmem_addr[8:0]];
    s_dmem_rdata <= mem[s_dmem_addr[8:0]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    beat_t b;
    if (dump_valid && dump_ready) begin
      $display("beat main: addr=%h word=%h last=%0b", dump_addr, dump_word, dump_last);
      if (exp_q.size() == 0) check_eq("main_unexpected_beat", dump_addr, 32'hBAD0_BEA7);
      else begin
        b = exp_q.pop_front();
        check_eq("main_word", dump_word, b.word);
        check_eq("main_addr", dump_addr, b.addr);
        check_eq("main_last", 32'(dump_last), 32'(b.last));
      end
    end
    if (s_dump_valid && s_dump_ready) begin
      $display("beat small: addr=%h word=%h last=%0b", s_dump_addr, s_dump_word, s_dump_last);
      if (exp_s_q.size() == 0) check_eq("small_unexpected_beat", s_dump_addr, 32'hBAD0_BEA7);
      else begin
        b = exp_s_q.pop_front();
        check_eq("small_word", s_dump_word, b.word);
        check_eq("small_addr", s_dump_addr, b.addr);
        check_eq("small_last", 32'(s_dump_last), 32'(b.last));
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_main;
    exp_q.push_back('{32'h0000_0007, 32'h0, 1'b0});
    exp_q.push_back('{32'h0000_002A, 32'h4, 1'b0});
    exp_q.push_back('{32'hDEAD_BEEF, 32'h8, !CHK});
    if (CHK) exp_q.push_back('{32'hDEAD_BEC2, 32'hFFFF_FFFF, 1'b1});
  endtask

  task automatic trap;
    instr_in = TRAP_HALT;
    tick;
    instr_in = 32'h0;
  endtask

  task automatic wait_valid(input int maxc, output int n);
    n = 0;
    while (!dump_valid && n < maxc) begin tick; n++; end
    if (!dump_valid) check_eq("valid_timeout", 32'(dump_valid), 32'd1);
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin tick; n++; end
    check_eq("done_reached", 32'(done), 32'd1);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    exp_q.delete();
    tick;
    tick;
    reset = 1'b1;
    tick;
  endtask

  initial begin
    int n;
    logic [31:0] held;
    logic [31:0] non_trap [4];
    non_trap = '{32'h4400_0301, 32'h0000_0300, 32'h0000_0000, 32'hC400_0300};
    foreach (mem[i]) mem[i] = 8'(i * 7 + 3);
    mem[0] = 8'h00; mem[1] = 8'h00; mem[2]  = 8'h00; mem[3]  = 8'h07;
    mem[4] = 8'h00; mem[5] = 8'h00; mem[6]  = 8'h00; mem[7]  = 8'h2A;
    mem[8] = 8'hDE; mem[9] = 8'hAD; mem[10] = 8'hBE; mem[11] = 8'hEF;
    mem[256] = 8'h12; mem[257] = 8'h34; mem[258] = 8'h56; mem[259] = 8'h78;
    reset = 1'b0; instr_in = 32'h0; dump_ready = 1'b1;
    s_instr = 32'h0; s_dump_ready = 1'b1;
    tick; tick;
    check_eq("rst_halt", 32'(halt), 0);
    check_eq("rst_dmem_rd", 32'(dmem_rd), 0);
    check_eq("rst_valid", 32'(dump_valid), 0);
    check_eq("rst_last", 32'(dump_last), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_dmem_addr", dmem_addr, 0);
    check_eq("rst_word", dump_word, 0);
    check_eq("rst_addr", dump_addr, 0);
    reset = 1'b1;
    tick;

    // Near-miss trap encodings must be ignored.
    foreach (non_trap[i]) begin
      instr_in = non_trap[i];
      tick;
      check_eq("nontrap_halt", 32'(halt), 0);
      check_eq("nontrap_rd", 32'(dmem_rd), 0);
      check_eq("nontrap_valid", 32'(dump_valid), 0);
    end
    instr_in = 32'h0;
    tick;

    // Basic three-word dump with ready held high.
    push_main();
    trap();
    check_eq("halt_after_trap", 32'(halt), 1);
    wait_valid(100, n);
    check_eq("trap_to_valid", 32'(n), 32'd11);
    wait_done(200);
    check_eq("queue_empty_basic", 32'(exp_q.size()), 0);
    trap();
    tick;
    check_eq("done_sticky", 32'(done), 1);
    check_eq("done_halt", 32'(halt), 1);
    check_eq("done_no_valid", 32'(dump_valid), 0);
    check_eq("done_no_rd", 32'(dmem_rd), 0);

    // Back-pressure on the second word.
    do_reset();
    dump_ready = 1'b0;
    push_main();
    trap();
    wait_valid(100, n);
    dump_ready = 1'b1;
    tick;
    dump_ready = 1'b0;
    wait_valid(100, n);
    held = dump_word;
    check_eq("stall_word1_addr", dump_addr, 32'h4);
    repeat (5) begin
      tick;
      check_eq("stall_valid", 32'(dump_valid), 1);
      check_eq("stall_word", dump_word, held);
      check_eq("stall_no_rd", 32'(dmem_rd), 0);
    end
    dump_ready = 1'b1;
    wait_done(200);
    check_eq("queue_empty_stall", 32'(exp_q.size()), 0);

    // Reset during READ of word 2, then a clean restart.
    do_reset();
    push_main();
    trap();
    n = 0;
    while (!(dmem_rd && dmem_addr == 32'h8) && n < 200) begin tick; n++; end
    check_eq("reached_word2_read", 32'(dmem_rd && dmem_addr == 32'h8), 1);
    reset = 1'b0;
    #1;
    check_eq("midrst_halt", 32'(halt), 0);
    check_eq("midrst_rd", 32'(dmem_rd), 0);
    check_eq("midrst_valid", 32'(dump_valid), 0);
    check_eq("midrst_word", dump_word, 0);
    check_eq("midrst_addr", dump_addr, 0);
    exp_q.delete();
    tick;
    reset = 1'b1;
    tick;
    push_main();
    trap();
    wait_valid(100, n);
    check_eq("restart_trap_to_valid", 32'(n), 32'd11);
    wait_done(200);
    check_eq("queue_empty_restart", 32'(exp_q.size()), 0);

    // Single word at 0x100 with no drain.
    exp_s_q.push_back('{32'h1234_5678, 32'h100, !CHK});
    if (CHK) exp_s_q.push_back('{32'h1234_5678, 32'hFFFF_FFFF, 1'b1});
    s_instr = TRAP_HALT;
    tick;
    s_instr = 32'h0;
    check_eq("small_halt", 32'(s_halt), 1);
    n = 0;
    while (!s_dump_valid && n < 100) begin tick; n++; end
    check_eq("small_trap_to_valid", 32'(n), 32'd6);
    n = 0;
    while (!s_done && n < 100) begin tick; n++; end
    check_eq("small_done", 32'(s_done), 1);
    check_eq("queue_empty_small", 32'(exp_s_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
